mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles from memory-port issue to mem_rdata valid (legal range 1..4).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port if_req, input, 1 bit, fetch-stage read request.
REQ-005 SHALL have port if_addr, input, `ISIZE bits, fetch address.
REQ-006 SHALL have ports if_rdata (output, `DSIZE bits, fetched instruction) and if_valid (output, 1 bit, one-cycle completion pulse).
REQ-007 SHALL have ports dm_req (input, 1), dm_wen (input, 1), dm_addr (input, `DSIZE), dm_wdata (input, `DSIZE): MEM-stage access.
REQ-008 SHALL have ports dm_rdata (output, `DSIZE) and dm_valid (output, 1): MEM-stage completion.
REQ-009 SHALL have outputs if_stall and dm_stall, 1 bit each, pipeline freeze requests.
REQ-010 SHALL have outputs mem_en, mem_wen (1 bit each), mem_addr, mem_wdata (`DSIZE each), and input mem_rdata (`DSIZE): shared single-port memory.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-012 In IDLE with any request, SHALL register the winner's addr/wdata/wen onto mem_*, pulse mem_en one cycle, load latency counter with MEM_LAT, and enter BUSY_IF or BUSY_DM.
REQ-013 mem_wen SHALL be 0 for fetch grants.
REQ-014 In BUSY_x, counter SHALL decrement each cycle; at zero, capture mem_rdata into x_rdata, pulse x_valid for exactly one cycle, return to IDLE.
REQ-015 Issue-to-valid latency SHALL be MEM_LAT+1 cycles; a new grant SHALL be possible the cycle after valid.
REQ-016 Writes SHALL also pulse dm_valid at completion; dm_rdata SHALL hold its prior value on writes.
REQ-017 if_stall SHALL equal if_req AND NOT if_valid; dm_stall SHALL equal dm_req AND NOT dm_valid (combinational).
REQ-018 Simultaneous if_req and dm_req in IDLE SHALL grant DM (older instruction) unless REQ-023 applies.
REQ-019 Request inputs SHALL be sampled only in IDLE; deasserting a request mid-transaction SHALL NOT abort it, valid still pulses.
REQ-020 x_rdata SHALL hold its value until the next completion for that requester.

Reset
REQ-021 On rst, asynchronously: state IDLE, counter 0, mem_en, mem_wen, if_valid, dm_valid 0; mem_addr, mem_wdata, if_rdata, dm_rdata 16'h0000.
REQ-022 Reset mid-transaction SHALL abort with no valid pulse; first grant occurs the first clk edge after rst deasserts.

Configuration
REQ-023 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate grants via a last-grant register (reset value: IF last, so DM wins first); undefined, fixed DM priority per REQ-018 and no last-grant register.

Verification
REQ-024 Lone if_req, if_addr=16'h0003, MEM_LAT=1, mem_rdata=16'hA5A5 -> mem_en pulse with mem_addr=3, mem_wen=0; if_valid pulse 2 cycles after grant; if_rdata=16'hA5A5; if_stall high until then.
REQ-025 dm_req, dm_wen=1, dm_addr=16'h0010, dm_wdata=16'h1234 -> mem_wen=1, mem_wdata=16'h1234; dm_valid pulses; dm_rdata unchanged.
REQ-026 if_req and dm_req held together, macro undefined -> DM always granted first, IF served next; macro defined -> grants alternate DM, IF, DM, IF.
REQ-027 MEM_LAT=3 fetch -> valid exactly 4 cycles after mem_en; no second mem_en in between.
REQ-028 rst asserted in BUSY_DM cycle 1 -> immediate IDLE, all outputs zero, no dm_valid pulse; after release, pending if_req granted on first edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage (IF)
// and the memory stage (DM). One access is in flight at a time; the winner's
// request is registered onto the memory port and completion is signalled by
// a one-cycle valid pulse MEM_LAT+1 cycles after issue.
// Optional build macro MEM_ARB_RR_EN: simultaneous requests alternate between
// DM and IF through a last-grant register; without it DM always wins ties.

`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [`ISIZE-1:0] if_addr,
  output logic [`DSIZE-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_wen,
  input  logic [`DSIZE-1:0] dm_addr,
  input  logic [`DSIZE-1:0] dm_wdata,
  output logic [`DSIZE-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [`DSIZE-1:0] mem_addr,
  output logic [`DSIZE-1:0] mem_wdata,
  input  logic [`DSIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t     state;
  logic [2:0] cnt;
  logic       grant_dm;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to IF, so DM is next in line on a tie
  logic last_if;

  // Tie-break alternates; a lone requester always wins
  always_comb begin
    grant_dm = 1'b0;
    if (dm_req && !if_req)
      grant_dm = 1'b1;
    else if (dm_req && if_req)
      grant_dm = last_if;
  end

  // Remember who received the last grant, regardless of whether it was a tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_if <= 1'b1;
    else if (state == IDLE && (if_req || dm_req))
      last_if <= !grant_dm;
  end
`else
  // Fixed priority: DM holds the older instruction so it wins any tie
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  // Freeze a stage while its request is outstanding and not yet completing
  always_comb begin
    if_stall = if_req && !if_valid;
    dm_stall = dm_req && !dm_valid;
  end

  // Arbitration FSM with registered memory-port and completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            mem_en <= 1'b1;
            cnt    <= LAT_INIT;
            if (grant_dm) begin
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_wen   <= dm_wen;
              state     <= BUSY_DM;
            end else begin
              mem_addr  <= `DSIZE'(if_addr);
              mem_wdata <= '0;
              mem_wen   <= 1'b0;
              state     <= BUSY_IF;
            end
          end
        end
        BUSY_IF: begin
          if (cnt == '0) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        BUSY_DM: begin
          if (cnt == '0) begin
            // mem_wen still reflects this access: writes leave dm_rdata alone
            if (!mem_wen)
              dm_rdata <= mem_rdata;
            dm_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a MEM_LAT=1 instance exercises
// arbitration, writes, request drop and reset abort; a MEM_LAT=3 instance
// covers the longer latency. Expected transactions are queued when driven
// and popped when the memory-port grant is observed.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wen;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid, if_stall, dm_stall;
  logic        mem_en, mem_wen;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        if3_req, dm3_req, dm3_wen;
  logic [15:0] if3_addr, dm3_addr, dm3_wdata;
  logic [15:0] if3_rdata, dm3_rdata;
  logic        if3_valid, dm3_valid, if3_stall, dm3_stall;
  logic        mem3_en, mem3_wen;
  logic [15:0] mem3_addr, mem3_wdata, mem3_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_dm;
    logic        wen;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .if_stall(if_stall), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_valid(if3_valid),
    .dm_req(dm3_req), .dm_wen(dm3_wen), .dm_addr(dm3_addr), .dm_wdata(dm3_wdata),
    .dm_rdata(dm3_rdata), .dm_valid(dm3_valid),
    .if_stall(if3_stall), .dm_stall(dm3_stall),
    .mem_en(mem3_en), .mem_wen(mem3_wen), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
  );

  // Power-on memory contents; address 3 holds 16'hA5A5
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[7:0]} ^ 16'hA6A6;
  endfunction

  // One-cycle-latency memory for the MEM_LAT=1 instance
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= memf(16'(i));
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[7:0]];
      if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // Three-cycle-latency read-only memory for the MEM_LAT=3 instance
  logic [15:0] rd3_0, rd3_1;
  always @(posedge clk) begin
    if (mem3_en) rd3_0 <= memf(mem3_addr);
    rd3_1      <= rd3_0;
    mem3_rdata <= rd3_1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_if(input logic [15:0] a);
    if_req  = 1'b1;
    if_addr = a;
    exp_q.push_back('{1'b0, 1'b0, a, 16'h0000, memf(a)});
  endtask

  task automatic drive_dm(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] r);
    dm_req   = 1'b1;
    dm_wen   = w;
    dm_addr  = a;
    dm_wdata = d;
    exp_q.push_back('{1'b1, w, a, d, r});
  endtask

  // Wait for the next grant, check it against the scoreboard, then follow the
  // access to its valid pulse. Returns on the negedge after the pulse.
  task automatic service(input string tag, input int exp_wait, input bit keep);
    txn_t e;
    int   n;
    int   c;
    bit   got;
    n = 0;
    while (!mem_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/grant_seen"}, mem_en, 1);
    if (!mem_en) return;
    chk({tag, "/grant_wait"}, n, exp_wait);
    if (exp_q.size() == 0) begin
      chk({tag, "/sb_entry"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "/mem_wen"}, mem_wen, e.wen);
    chk({tag, "/mem_addr"}, mem_addr, e.addr);
    if (e.is_dm) chk({tag, "/mem_wdata"}, mem_wdata, e.wdata);
    got = 1'b0;
    c   = 0;
    while (!got && c < 10) begin
      @(negedge clk);
      c++;
      if (e.is_dm ? dm_valid : if_valid) begin
        got = 1'b1;
      end else begin
        chk({tag, "/no_reissue"}, mem_en, 0);
        chk({tag, "/stall"}, e.is_dm ? dm_stall : if_stall, e.is_dm ? dm_req : if_req);
      end
      chk({tag, "/other_valid"}, e.is_dm ? if_valid : dm_valid, 0);
    end
    chk({tag, "/valid_seen"}, got, 1);
    if (!got) return;
    chk({tag, "/latency"}, c, LAT1 + 1);
    chk({tag, "/rdata"}, e.is_dm ? dm_rdata : if_rdata, e.rdata);
    chk({tag, "/stall_on_valid"}, e.is_dm ? dm_stall : if_stall, 0);
    if (!keep) begin
      if (e.is_dm) dm_req = 1'b0;
      else         if_req = 1'b0;
    end
    @(negedge clk);
    chk({tag, "/one_cycle_pulse"}, e.is_dm ? dm_valid : if_valid, 0);
    chk({tag, "/rdata_hold"}, e.is_dm ? dm_rdata : if_rdata, e.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wen = 1'b0; dm_addr = '0; dm_wdata = '0;
    if3_req = 1'b0; if3_addr = '0;
    dm3_req = 1'b0; dm3_wen = 1'b0; dm3_addr = '0; dm3_wdata = '0;
    repeat (3) @(negedge clk);

    chk("reset/mem_en", mem_en, 0);
    chk("reset/mem_wen", mem_wen, 0);
    chk("reset/mem_addr", mem_addr, 16'h0000);
    chk("reset/mem_wdata", mem_wdata, 16'h0000);
    chk("reset/if_valid", if_valid, 0);
    chk("reset/dm_valid", dm_valid, 0);
    chk("reset/if_rdata", if_rdata, 16'h0000);
    chk("reset/dm_rdata", dm_rdata, 16'h0000);
    chk("reset/stalls", {if_stall, dm_stall}, 2'b00);
    chk("reset/dut3_mem_en", mem3_en, 0);
    rst = 1'b0;

    // Lone fetch from address 3
    drive_if(16'h0003);
    #1;
    chk("fetch3/if_stall_comb", if_stall, 1);
    chk("fetch3/dm_stall_comb", dm_stall, 0);
    service("fetch3", 1, 0);

    // Read, write (dm_rdata must hold), read back the written word
    drive_dm(1'b0, 16'h0005, 16'h0000, memf(16'h0005));
    service("dm_rd5", 1, 0);
    drive_dm(1'b1, 16'h0010, 16'h1234, memf(16'h0005));
    service("dm_wr10", 1, 0);
    drive_dm(1'b0, 16'h0010, 16'h0000, 16'h1234);
    service("dm_rd10", 1, 0);

    // Request dropped right after grant still completes
    drive_dm(1'b0, 16'h0021, 16'h0000, memf(16'h0021));
    @(negedge clk);
    dm_req = 1'b0;
    service("dm_drop", 0, 0);

    // Simultaneous requests from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_ARB_RR_EN
    drive_dm(1'b0, 16'h0008, 16'h0000, memf(16'h0008));
    drive_if(16'h0007);
    drive_dm(1'b0, 16'h0008, 16'h0000, memf(16'h0008));
    drive_if(16'h0007);
    drive_dm(1'b0, 16'h0008, 16'h0000, memf(16'h0008));
    service("rr_dm1", 1, 1);
    service("rr_if1", 0, 1);
    service("rr_dm2", 0, 1);
    service("rr_if2", 0, 0);
    service("rr_dm3", 0, 0);
`else
    drive_dm(1'b0, 16'h0008, 16'h0000, memf(16'h0008));
    drive_if(16'h0007);
    service("pri_dm", 1, 0);
    service("pri_if", 0, 0);
`endif

    // Reset during the first busy cycle of a DM access
    drive_dm(1'b0, 16'h0030, 16'h0000, memf(16'h0030));
    @(negedge clk);
    chk("rst_mid/grant", mem_en, 1);
    chk("rst_mid/grant_addr", mem_addr, 16'h0030);
    rst = 1'b1;
    dm_req = 1'b0;
    if_req = 1'b1;
    if_addr = 16'h0009;
    #1;
    chk("rst_mid/mem_en", mem_en, 0);
    chk("rst_mid/mem_addr", mem_addr, 16'h0000);
    chk("rst_mid/mem_wen_wdata", {mem_wen, mem_wdata}, 17'h0);
    chk("rst_mid/rdatas", {if_rdata, dm_rdata}, 32'h0);
    chk("rst_mid/valids", {if_valid, dm_valid}, 2'b00);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk("rst_mid/no_dm_valid", dm_valid, 0);
    chk("rst_mid/sb_empty", exp_q.size(), 0);
    exp_q.push_back('{1'b0, 1'b0, 16'h0009, 16'h0000, memf(16'h0009)});
    rst = 1'b0;
    service("after_rst_if", 1, 0);

    // MEM_LAT=3 fetch
    if3_req  = 1'b1;
    if3_addr = 16'h0004;
    n = 0;
    while (!mem3_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lat3/grant_seen", mem3_en, 1);
    chk("lat3/grant_wait", n, 1);
    chk("lat3/mem_addr", mem3_addr, 16'h0004);
    chk("lat3/mem_wen", mem3_wen, 0);
    c = 0;
    while (c < 12) begin
      @(negedge clk);
      c++;
      if (if3_valid) break;
      chk("lat3/no_reissue", mem3_en, 0);
    end
    chk("lat3/latency", c, 4);
    chk("lat3/rdata", if3_rdata, memf(16'h0004));
    if3_req = 1'b0;
    @(negedge clk);
    chk("lat3/one_cycle_pulse", if3_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
